mcu_parallel_bridge: RTL and testbench

Parametrised successor to the STM32 8-bit parallel bus interface: a command-framed byte bridge between the MCU bus (DATA_BUS/DATA_SYNC) and the FPGA datapath. Adds N-channel RX IQ streaming with a per-channel enable mask, configurable sample width, a checksummed parameter register file with atomic commit, sticky overrun/error flags, and a generic status readback. It sits between the MCU pins and the DDC/DUC cores.

---
 rtl/mcu_bridge_pkg.sv | 32 +++
 rtl/rx_iq_holding.sv | 55 +++++
 rtl/mcu_parallel_bridge.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mcu_parallel_bridge.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_bridge_pkg.sv
// Shared definitions for the MCU parallel bridge: command opcodes, check seed,
// FSM state encoding and flag/header bit positions.
package mcu_bridge_pkg;

  localparam logic [7:0] CmdBusTest     = 8'h00;
  localparam logic [7:0] CmdParamWrite  = 8'h01;
  localparam logic [7:0] CmdStatusRead  = 8'h02;
  localparam logic [7:0] CmdTxIq        = 8'h03;
  localparam logic [7:0] CmdRxIq        = 8'h04;
  localparam logic [7:0] CmdSoftRstSet  = 8'h05;
  localparam logic [7:0] CmdSoftRstClr  = 8'h06;

  localparam logic [7:0] ParamCheckSeed = 8'hA5;

  localparam int unsigned FlagOverrunBit = 0;
  localparam int unsigned FlagCmdErrBit  = 1;
  localparam int unsigned HdrFreshBit    = 0;
  localparam int unsigned HdrOverrunBit  = 1;

  typedef enum logic [3:0] {
    StIdle,
    StEchoRx,
    StEchoTx,
    StParamRx,
    StParamChk,
    StStatTx,
    StTxiqRx,
    StRxiqHdr,
    StRxiqData
  } bridge_state_e;

endpackage

// File: rtl/rx_iq_holding.sv
// RX IQ holding register: captures every rx_valid set, tracks freshness and
// overrun, and hands a stable snapshot to the byte streamer on request.
module rx_iq_holding
  import mcu_bridge_pkg::*;
#(
  parameter int unsigned NUM_RX   = 2,
  parameter int unsigned SAMPLE_W = 24
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic [NUM_RX*SAMPLE_W-1:0] rx_i_i,
  input  logic [NUM_RX*SAMPLE_W-1:0] rx_q_i,
  input  logic                       valid_i,
  input  logic                       take_i,
  output logic [NUM_RX*SAMPLE_W-1:0] snap_i_o,
  output logic [NUM_RX*SAMPLE_W-1:0] snap_q_o,
  output logic                       fresh_o,
  output logic                       overrun_o
);

  logic [NUM_RX*SAMPLE_W-1:0] hold_i_q, hold_q_q;
  logic [NUM_RX*SAMPLE_W-1:0] snap_i_q, snap_q_q;
  logic                       fresh_q;

  assign overrun_o = valid_i & fresh_q;
  assign fresh_o   = fresh_q;
  assign snap_i_o  = snap_i_q;
  assign snap_q_o  = snap_q_q;

  // A snapshot coinciding with rx_valid takes the old data; the new set stays fresh.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hold_i_q <= '0;
      hold_q_q <= '0;
      snap_i_q <= '0;
      snap_q_q <= '0;
      fresh_q  <= 1'b0;
    end else begin
      if (valid_i) begin
        hold_i_q <= rx_i_i;
        hold_q_q <= rx_q_i;
      end
      if (take_i) begin
        snap_i_q <= hold_i_q;
        snap_q_q <= hold_q_q;
      end
      if (valid_i) begin
        fresh_q <= 1'b1;
      end else if (take_i) begin
        fresh_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mcu_parallel_bridge.sv
// Command-framed byte bridge between the MCU 8-bit parallel bus and the FPGA
// datapath: echo test, parameter file with checked commit, status, TX and RX IQ.
module mcu_parallel_bridge
  import mcu_bridge_pkg::*;
#(
  parameter int unsigned NUM_RX       = 2,
  parameter int unsigned SAMPLE_W     = 24,
  parameter int unsigned PARAM_BYTES  = 16,
  parameter int unsigned STATUS_BYTES = 8,
  parameter logic [PARAM_BYTES*8-1:0] PARAM_RESET = '0
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       DATA_SYNC,
  inout  wire  [7:0]                 DATA_BUS,
  input  logic [NUM_RX*SAMPLE_W-1:0] rx_i,
  input  logic [NUM_RX*SAMPLE_W-1:0] rx_q,
  input  logic                       rx_valid,
  output logic [NUM_RX-1:0]          rx_chan_en,
  output logic [SAMPLE_W-1:0]        tx_i,
  output logic [SAMPLE_W-1:0]        tx_q,
  output logic                       tx_iq_valid,
  output logic [PARAM_BYTES*8-1:0]   param_regs,
  output logic                       param_update,
  input  logic [STATUS_BYTES*8-1:0]  status_in,
  output logic                       soft_reset,
  output logic                       iq_overrun,
  output logic                       cmd_err,
  output logic                       bus_oe
);

  localparam int unsigned SB  = SAMPLE_W / 8;
  localparam int unsigned CW  = 6;
  localparam int unsigned ChW = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;

  localparam logic [CW-1:0] LastParam = CW'(PARAM_BYTES - 1);
  localparam logic [CW-1:0] LastIq    = CW'(2 * SB - 1);
  localparam logic [CW-1:0] StatLast  = CW'(STATUS_BYTES);

  bridge_state_e              state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [ChW-1:0]             chan_q, chan_d;
  logic [7:0]                 out_q, out_d;
  logic [7:0]                 chk_q, chk_d;
  logic [PARAM_BYTES*8-1:0]   shadow_q, shadow_d;
  logic [2*SAMPLE_W-1:0]      txsh_q, txsh_d;
  logic [SAMPLE_W-1:0]        tx_i_q, tx_i_d, tx_q_q, tx_q_d;
  logic                       tx_valid_q, tx_valid_d;
  logic [PARAM_BYTES*8-1:0]   param_q, param_d;
  logic                       upd_q, upd_d;
  logic [NUM_RX-1:0]          mask_q, mask_d;
  logic                       soft_q, soft_d;
  logic                       ovr_q, ovr_d, err_q, err_d;

  logic                       take, flag_clr, err_evt, ovr_evt, fresh;
  logic [NUM_RX*SAMPLE_W-1:0] snap_i, snap_q;
  logic [SAMPLE_W-1:0]        smp;
  logic [ChW:0]               nxt;
  int                         bidx, sidx;

  rx_iq_holding #(
    .NUM_RX  (NUM_RX),
    .SAMPLE_W(SAMPLE_W)
  ) u_holding (
    .clk_in   (clk_in),
    .reset    (reset),
    .rx_i_i   (rx_i),
    .rx_q_i   (rx_q),
    .valid_i  (rx_valid),
    .take_i   (take),
    .snap_i_o (snap_i),
    .snap_q_o (snap_q),
    .fresh_o  (fresh),
    .overrun_o(ovr_evt)
  );

  // Lowest enabled channel at or above 'from'; MSB of the result flags a hit.
  function automatic logic [ChW:0] next_en(input logic [NUM_RX-1:0] mask, input int from);
    next_en = '0;
    for (int c = NUM_RX - 1; c >= 0; c--) begin
      if (c >= from && mask[c]) next_en = {1'b1, ChW'(c)};
    end
  endfunction

  assign bus_oe = (state_q == StEchoTx) || (state_q == StStatTx) ||
                  (state_q == StRxiqHdr) || (state_q == StRxiqData);

  // Release the pad while the MCU presents a new command.
  assign DATA_BUS = (bus_oe && !DATA_SYNC) ? out_q : 8'hzz;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    chan_d     = chan_q;
    out_d      = out_q;
    chk_d      = chk_q;
    shadow_d   = shadow_q;
    txsh_d     = txsh_q;
    tx_i_d     = tx_i_q;
    tx_q_d     = tx_q_q;
    tx_valid_d = 1'b0;
    param_d    = param_q;
    upd_d      = 1'b0;
    mask_d     = mask_q;
    soft_d     = soft_q;
    take       = 1'b0;
    flag_clr   = 1'b0;
    err_evt    = 1'b0;
    nxt        = '0;
    smp        = '0;
    bidx       = 0;
    sidx       = 0;

    if (DATA_SYNC) begin
      cnt_d  = '0;
      chan_d = '0;
      chk_d  = ParamCheckSeed;
      case (DATA_BUS)
        CmdBusTest:    state_d = StEchoRx;
        CmdParamWrite: state_d = StParamRx;
        CmdStatusRead: state_d = StStatTx;
        CmdTxIq:       state_d = StTxiqRx;
        CmdRxIq:       state_d = StRxiqHdr;
        CmdSoftRstSet: begin
          soft_d  = 1'b1;
          state_d = StIdle;
        end
        CmdSoftRstClr: begin
          soft_d  = 1'b0;
          state_d = StIdle;
        end
        default: begin
          err_evt = 1'b1;
          state_d = StIdle;
        end
      endcase
    end else begin
      case (state_q)
        StEchoRx: begin
          out_d   = DATA_BUS;
          state_d = StEchoTx;
        end
        StEchoTx: state_d = StEchoRx;
        StParamRx: begin
          shadow_d[int'(cnt_q)*8 +: 8] = DATA_BUS;
          chk_d = chk_q ^ DATA_BUS;
          if (cnt_q == LastParam) state_d = StParamChk;
          else cnt_d = cnt_q + 1'b1;
        end
        StParamChk: begin
          if (DATA_BUS == chk_q) begin
            param_d = shadow_q;
            mask_d  = shadow_q[NUM_RX-1:0];
            upd_d   = 1'b1;
          end else begin
            err_evt = 1'b1;
          end
          state_d = StIdle;
        end
        StStatTx: begin
          if (cnt_q == '0) begin
            out_d                 = '0;
            out_d[FlagOverrunBit] = ovr_q;
            out_d[FlagCmdErrBit]  = err_q;
            flag_clr              = 1'b1;
            cnt_d                 = cnt_q + 1'b1;
          end else if (cnt_q <= StatLast) begin
            sidx  = int'(STATUS_BYTES) - int'(cnt_q);
            out_d = status_in[sidx*8 +: 8];
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
        StTxiqRx: begin
          txsh_d = {txsh_q[2*SAMPLE_W-9:0], DATA_BUS};
          if (cnt_q == LastIq) begin
            {tx_q_d, tx_i_d} = txsh_d;
            tx_valid_d       = 1'b1;
            state_d          = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRxiqHdr: begin
          out_d                = '0;
          out_d[HdrFreshBit]   = fresh;
          out_d[HdrOverrunBit] = ovr_q;
          take                 = 1'b1;
          nxt                  = next_en(mask_q, 0);
          if (nxt[ChW]) begin
            chan_d  = nxt[ChW-1:0];
            cnt_d   = '0;
            state_d = StRxiqData;
          end
        end
        StRxiqData: begin
          if (cnt_q < CW'(SB)) begin
            smp  = snap_q[int'(chan_q)*SAMPLE_W +: SAMPLE_W];
            bidx = int'(SB) - 1 - int'(cnt_q);
          end else begin
            smp  = snap_i[int'(chan_q)*SAMPLE_W +: SAMPLE_W];
            bidx = 2 * int'(SB) - 1 - int'(cnt_q);
          end
          out_d = smp[bidx*8 +: 8];
          if (cnt_q == LastIq) begin
            cnt_d = '0;
            nxt   = next_en(mask_q, int'(chan_q) + 1);
            if (nxt[ChW]) chan_d = nxt[ChW-1:0];
            else state_d = StRxiqHdr;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // A flag event in the clearing cycle wins.
    ovr_d = (ovr_q & ~flag_clr) | ovr_evt;
    err_d = (err_q & ~flag_clr) | err_evt;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      chan_q     <= '0;
      out_q      <= '0;
      chk_q      <= '0;
      shadow_q   <= '0;
      txsh_q     <= '0;
      tx_i_q     <= '0;
      tx_q_q     <= '0;
      tx_valid_q <= 1'b0;
      param_q    <= PARAM_RESET;
      upd_q      <= 1'b0;
      mask_q     <= NUM_RX'(1);
      soft_q     <= 1'b0;
      ovr_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      chan_q     <= chan_d;
      out_q      <= out_d;
      chk_q      <= chk_d;
      shadow_q   <= shadow_d;
      txsh_q     <= txsh_d;
      tx_i_q     <= tx_i_d;
      tx_q_q     <= tx_q_d;
      tx_valid_q <= tx_valid_d;
      param_q    <= param_d;
      upd_q      <= upd_d;
      mask_q     <= mask_d;
      soft_q     <= soft_d;
      ovr_q      <= ovr_d;
      err_q      <= err_d;
    end
  end

  assign rx_chan_en   = mask_q;
  assign tx_i         = tx_i_q;
  assign tx_q         = tx_q_q;
  assign tx_iq_valid  = tx_valid_q;
  assign param_regs   = param_q;
  assign param_update = upd_q;
  assign soft_reset   = soft_q;
  assign iq_overrun   = ovr_q;
  assign cmd_err      = err_q;

endmodule

// File: tb/tb_mcu_parallel_bridge.sv
// Directed + randomized bench for mcu_parallel_bridge against a byte-level
// reference model of the bus protocol.
module tb_mcu_parallel_bridge;

  localparam int unsigned NRX = 2;
  localparam int unsigned SW  = 24;
  localparam int unsigned PB  = 4;
  localparam int unsigned STB = 3;
  localparam int unsigned SB  = SW / 8;
  localparam logic [PB*8-1:0] PRST = 32'hDEADBE01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync = 1'b0;
  logic mcu_oe = 1'b0;
  logic [7:0] mcu_byte = 8'h00;
  wire  [7:0] data_bus;
  assign data_bus = mcu_oe ? mcu_byte : 8'hzz;

  logic [NRX*SW-1:0] rx_i = '0, rx_q = '0;
  logic              rx_valid = 1'b0;
  logic [STB*8-1:0]  status_in = '0;
  logic [NRX-1:0]    rx_chan_en;
  logic [SW-1:0]     tx_i, tx_q;
  logic              tx_iq_valid, param_update, soft_reset, iq_overrun, cmd_err, bus_oe;
  logic [PB*8-1:0]   param_regs;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [PB*8-1:0] m_param;
  logic [NRX-1:0]  m_mask;
  logic [SW-1:0]   m_txi, m_txq;
  logic            m_ovr, m_err, m_soft, m_fresh;
  logic [SW-1:0]   m_hold_i[NRX], m_hold_q[NRX], m_snap_i[NRX], m_snap_q[NRX];

  logic [7:0]      b;
  logic [PB*8-1:0] pdata;

  mcu_parallel_bridge #(
    .NUM_RX      (NRX),
    .SAMPLE_W    (SW),
    .PARAM_BYTES (PB),
    .STATUS_BYTES(STB),
    .PARAM_RESET (PRST)
  ) dut (
    .clk_in      (clk),
    .reset       (rst),
    .DATA_SYNC   (sync),
    .DATA_BUS    (data_bus),
    .rx_i        (rx_i),
    .rx_q        (rx_q),
    .rx_valid    (rx_valid),
    .rx_chan_en  (rx_chan_en),
    .tx_i        (tx_i),
    .tx_q        (tx_q),
    .tx_iq_valid (tx_iq_valid),
    .param_regs  (param_regs),
    .param_update(param_update),
    .status_in   (status_in),
    .soft_reset  (soft_reset),
    .iq_overrun  (iq_overrun),
    .cmd_err     (cmd_err),
    .bus_oe      (bus_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_param = PRST;
    m_mask  = NRX'(1);
    m_txi   = '0;
    m_txq   = '0;
    m_ovr   = 1'b0;
    m_err   = 1'b0;
    m_soft  = 1'b0;
    m_fresh = 1'b0;
    for (int c = 0; c < NRX; c++) begin
      m_hold_i[c] = '0;
      m_hold_q[c] = '0;
      m_snap_i[c] = '0;
      m_snap_q[c] = '0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " bus_oe"}, bus_oe, 1'b0);
    check({tag, " mask"}, rx_chan_en, m_mask);
    check({tag, " param"}, param_regs, m_param);
    check({tag, " tx_q"}, tx_q, m_txq);
    check({tag, " tx_i"}, tx_i, m_txi);
    check({tag, " overrun"}, iq_overrun, m_ovr);
    check({tag, " cmd_err"}, cmd_err, m_err);
    check({tag, " soft"}, soft_reset, m_soft);
  endtask

  task automatic cmd(input logic [7:0] c);
    sync = 1'b1;
    mcu_oe = 1'b1;
    mcu_byte = c;
    tick();
    sync = 1'b0;
    mcu_oe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] v);
    mcu_oe = 1'b1;
    mcu_byte = v;
    tick();
    mcu_oe = 1'b0;
  endtask

  task automatic rd(output logic [7:0] v);
    tick();
    v = data_bus;
  endtask

  task automatic pulse_rx(input logic [NRX*SW-1:0] vi, input logic [NRX*SW-1:0] vq);
    rx_i = vi;
    rx_q = vq;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    if (m_fresh) m_ovr = 1'b1;
    m_fresh = 1'b1;
    for (int c = 0; c < NRX; c++) begin
      m_hold_i[c] = vi[c*SW +: SW];
      m_hold_q[c] = vq[c*SW +: SW];
    end
  endtask

  task automatic param_write(input logic [PB*8-1:0] data, input logic [7:0] chk,
                             input string tag);
    logic [7:0] x;
    logic       good;
    x = 8'hA5;
    cmd(8'h01);
    for (int n = 0; n < PB; n++) begin
      wr(data[n*8 +: 8]);
      x = x ^ data[n*8 +: 8];
    end
    wr(chk);
    good = (chk == x);
    if (good) begin
      m_param = data;
      m_mask  = data[NRX-1:0];
    end else begin
      m_err = 1'b1;
    end
    check({tag, " param"}, param_regs, m_param);
    check({tag, " update"}, param_update, good);
    check({tag, " mask"}, rx_chan_en, m_mask);
    check({tag, " cmd_err"}, cmd_err, m_err);
    tick();
    check({tag, " update end"}, param_update, 1'b0);
  endtask

  task automatic status_read(input string tag);
    logic [7:0] v;
    cmd(8'h02);
    check({tag, " oe"}, bus_oe, 1'b1);
    rd(v);
    check({tag, " flags"}, v, {6'b0, m_err, m_ovr});
    m_err = 1'b0;
    m_ovr = 1'b0;
    check({tag, " ovr clr"}, iq_overrun, m_ovr);
    check({tag, " err clr"}, cmd_err, m_err);
    for (int k = STB - 1; k >= 0; k--) begin
      rd(v);
      check($sformatf("%s status%0d", tag, k), v, status_in[k*8 +: 8]);
    end
    tick();
    check({tag, " oe off"}, bus_oe, 1'b0);
  endtask

  task automatic rx_stream(input int sets, input string tag);
    logic [7:0] v, e;
    cmd(8'h04);
    check({tag, " oe"}, bus_oe, 1'b1);
    for (int s = 0; s < sets; s++) begin
      rd(v);
      check($sformatf("%s hdr%0d", tag, s), v, {6'b0, m_ovr, m_fresh});
      for (int c = 0; c < NRX; c++) begin
        m_snap_i[c] = m_hold_i[c];
        m_snap_q[c] = m_hold_q[c];
      end
      m_fresh = 1'b0;
      for (int c = 0; c < NRX; c++) begin
        if (m_mask[c]) begin
          for (int k = 0; k < 2 * SB; k++) begin
            rd(v);
            if (k < SB) e = m_snap_q[c][(SB-1-k)*8 +: 8];
            else e = m_snap_i[c][(2*SB-1-k)*8 +: 8];
            check($sformatf("%s s%0d ch%0d b%0d", tag, s, c, k), v, e);
          end
        end
      end
    end
    cmd(8'h06);
    m_soft = 1'b0;
    check({tag, " oe off"}, bus_oe, 1'b0);
  endtask

  task automatic tx_iq(input logic [SW-1:0] q, input logic [SW-1:0] i, input string tag);
    cmd(8'h03);
    for (int n = 0; n < 2 * SB; n++) begin
      if (n < SB) wr(q[(SB-1-n)*8 +: 8]);
      else wr(i[(2*SB-1-n)*8 +: 8]);
      if (n == 2 * SB - 1) begin
        m_txq = q;
        m_txi = i;
      end
      check($sformatf("%s valid%0d", tag, n), tx_iq_valid, (n == 2 * SB - 1));
    end
    check({tag, " tx_q"}, tx_q, m_txq);
    check({tag, " tx_i"}, tx_i, m_txi);
    tick();
    check({tag, " valid end"}, tx_iq_valid, 1'b0);
  endtask

  initial begin
    model_reset();
    status_in = STB*8'($urandom);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_state("reset");
    check("reset update", param_update, 1'b0);
    check("reset tx_valid", tx_iq_valid, 1'b0);

    // Bus test: receive slot, echo slot, alternating.
    cmd(8'h00);
    check("echo rx oe", bus_oe, 1'b0);
    wr(8'h5A);
    check("echo0 oe", bus_oe, 1'b1);
    check("echo0 data", data_bus, 8'h5A);
    tick();
    check("echo rx1 oe", bus_oe, 1'b0);
    wr(8'hC3);
    check("echo1 oe", bus_oe, 1'b1);
    check("echo1 data", data_bus, 8'hC3);
    for (int n = 0; n < 3; n++) begin
      logic [7:0] r;
      r = 8'($urandom);
      tick();
      wr(r);
      check($sformatf("echo rand%0d", n), data_bus, r);
    end
    cmd(8'h06);

    // Parameter file: good check, bad check, status readback of flags.
    param_write(32'h04030201, 8'hA1, "pw fixed");
    check("pw fixed value", param_regs, 32'h04030201);
    param_write(32'h0A0B0C0D, 8'h00, "pw bad");
    status_read("st err");
    status_read("st clean");

    pdata = ($urandom & ~32'h3) | 32'h2;
    begin
      logic [7:0] x;
      x = 8'hA5;
      for (int n = 0; n < PB; n++) x = x ^ pdata[n*8 +: 8];
      param_write(pdata, x, "pw mask10");
    end

    // Channel 1 only.
    pulse_rx({24'hABCDEF, 24'($urandom)}, {24'h123456, 24'($urandom)});
    rx_stream(2, "rx ch1");

    pdata = $urandom | 32'h3;
    begin
      logic [7:0] x;
      x = 8'hA5;
      for (int n = 0; n < PB; n++) x = x ^ pdata[n*8 +: 8];
      param_write(pdata, x, "pw mask11");
    end
    pulse_rx({24'($urandom), 24'($urandom)}, {24'($urandom), 24'($urandom)});
    rx_stream(2, "rx both");

    // Overrun: two sets without a snapshot.
    pulse_rx({24'($urandom), 24'($urandom)}, {24'($urandom), 24'($urandom)});
    pulse_rx({24'($urandom), 24'($urandom)}, {24'($urandom), 24'($urandom)});
    check("overrun set", iq_overrun, m_ovr);
    rx_stream(1, "rx ovr");
    status_read("st ovr");
    status_read("st ovr clean");

    // Zero mask: header-only sets.
    pdata = $urandom & ~32'h3;
    begin
      logic [7:0] x;
      x = 8'hA5;
      for (int n = 0; n < PB; n++) x = x ^ pdata[n*8 +: 8];
      param_write(pdata, x, "pw mask00");
    end
    pulse_rx({24'($urandom), 24'($urandom)}, {24'($urandom), 24'($urandom)});
    rx_stream(3, "rx none");

    // TX IQ: fixed, random, aborted.
    tx_iq(24'hFFFFFE, 24'h000002, "tx fixed");
    tx_iq(24'($urandom), 24'($urandom), "tx rand");
    cmd(8'h03);
    for (int n = 0; n < 4; n++) begin
      wr(8'($urandom));
      check($sformatf("tx abort valid%0d", n), tx_iq_valid, 1'b0);
    end
    cmd(8'h06);
    check("tx abort q", tx_q, m_txq);
    check("tx abort i", tx_i, m_txi);
    tick();
    check("tx abort valid", tx_iq_valid, 1'b0);

    // Soft reset control and invalid command.
    cmd(8'h05);
    m_soft = 1'b1;
    check("soft set", soft_reset, m_soft);
    cmd(8'h06);
    m_soft = 1'b0;
    check("soft clr", soft_reset, m_soft);
    cmd(8'h05);
    m_soft = 1'b1;
    cmd(8'h7E);
    m_err = 1'b1;
    check("bad cmd err", cmd_err, m_err);
    check("bad cmd oe", bus_oe, 1'b0);
    check("bad cmd soft", soft_reset, m_soft);

    // Asynchronous reset in the middle of an RX stream.
    pdata = $urandom | 32'h3;
    begin
      logic [7:0] x;
      x = 8'hA5;
      for (int n = 0; n < PB; n++) x = x ^ pdata[n*8 +: 8];
      param_write(pdata, x, "pw pre-reset");
    end
    pulse_rx({24'($urandom), 24'($urandom)}, {24'($urandom), 24'($urandom)});
    cmd(8'h04);
    rd(b);
    check("pre-reset hdr", b, {6'b0, m_ovr, m_fresh});
    rd(b);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state("mid reset");
    #2;
    rst = 1'b0;
    tick();
    rx_stream(1, "post reset rx");
    tx_iq(24'($urandom), 24'($urandom), "post reset tx");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
